instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage that drives the producer side of the IF/ID pipeline register.
- Issues single-outstanding requests to instruction memory at the current PC and captures the returned word.
- Presents instruction_next, pc_next and pc_plus_four_next with a valid/stall handshake into the instruction register.
- Handles branch/jump redirects, including discarding responses that are in flight.

Parameters:
n, 32, data/address width in bits
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
imem_req  output  1  request to instruction memory
imem_addr  output  n  request address, equals current pc
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  n  read data
stall  input  1  downstream not accepting; hold outputs
redirect  input  1  branch/jump taken, restart fetch
redirect_pc  input  n  new fetch target
instruction_next  output  n  fetched instruction to IF/ID register
pc_next  output  n  address of instruction_next
pc_plus_four_next  output  n  pc_next + 4
fetch_valid  output  1  outputs hold a valid instruction

Behaviour:
- FSM states: IDLE, REQ, WAIT, HOLD.
- Internal registers: pc and a drop flag.
- Reset (reset=0, async):
  - state=IDLE, pc=RESET_PC, drop=0.
  - instruction_next=NOP (32'h0000_0013), pc_next=0, pc_plus_four_next=0, fetch_valid=0.
  - imem_req=0, imem_addr=RESET_PC.
- imem_req=1 only in REQ. imem_addr=pc always.
- IDLE: go to REQ on the next clock, unconditionally.
- REQ:
  - gnt & !redirect: go to WAIT, drop<=0.
  - gnt & redirect: go to WAIT, drop<=1, pc<=redirect_pc.
  - !gnt & redirect: pc<=redirect_pc, stay in REQ.
  - Otherwise stay in REQ.
- WAIT:
  - rvalid & !drop & !redirect: instruction_next<=rdata, pc_next<=pc, pc_plus_four_next<=pc+4, fetch_valid<=1, pc<=pc+4; go to HOLD.
  - rvalid & (drop | redirect): discard data, drop<=0, pc<=redirect_pc if redirect; go to REQ.
  - !rvalid & redirect: pc<=redirect_pc, drop<=1, stay in WAIT.
- HOLD:
  - redirect: fetch_valid<=0, pc<=redirect_pc; go to REQ. Redirect beats stall.
  - !stall: instruction consumed this edge; fetch_valid<=0; go to REQ.
  - stall: all outputs held stable.
- Latency and throughput:
  - Minimum latency is gnt in cycle t, rvalid in cycle t+1, fetch_valid=1 from cycle t+2.
  - Peak throughput is one instruction per 3 cycles.
- Arithmetic: pc+4 is modulo 2^n; 32'hFFFF_FFFC wraps to 0.
- Boundaries:
  - imem_rvalid outside WAIT is ignored, including stale responses after reset.
  - Redirect is evaluated every cycle; the last redirect wins.
  - Reset mid-operation abandons the outstanding request; its response is ignored.
  - Each clock edge on which fetch_valid=1 and stall=0 transfers exactly one instruction.

Optional Feature:
FETCH_ALIGN_CHK_EN
- Defined:
  - Adds output port fetch_misalign (1 bit).
  - On redirect with redirect_pc[1:0]!=0: pc<=redirect_pc with bits [1:0] cleared, and fetch_misalign pulses high for one cycle.
  - fetch_misalign resets to 0.
- Undefined: the port is absent and redirect_pc is loaded unmodified.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {IDLE, REQ, WAIT, HOLD}.
  - localparam NOP_INSTR=32'h0000_0013.
  - localparam INSTR_BYTES=4.
- One natural sub-module, pc_gen:
  - Holds the pc register plus +4 / redirect muxing (and alignment masking when enabled).
  - instr_fetch retains the FSM, the drop flag and the output registers.

Test Plan:
- Reset then gnt=1 in REQ, rvalid=1 next cycle with rdata=55 -> fetch_valid=1 with instruction_next=55, pc_next=0, pc_plus_four_next=4; next imem_addr=4.
- Hold stall=1 for 3 cycles in HOLD -> outputs stable and imem_req=0; stall=0 -> fetch_valid=0 next cycle, REQ at addr 4.
- Redirect to 250 while in WAIT, then rvalid with rdata=99 -> 99 never appears, fetch_valid stays 0, next imem_addr=250.
- Redirect to 1444 same cycle as stall=1 in HOLD -> fetch_valid=0, imem_addr=1444.
- RESET_PC=32'hFFFF_FFFC, one fetch -> pc_plus_four_next=0, next imem_addr=0.
- Assert reset in WAIT, release, inject stale rvalid in REQ -> ignored, fetch_valid=0, imem_addr=RESET_PC; with FETCH_ALIGN_CHK_EN, redirect to 250 -> imem_addr=248, fetch_misalign pulses once.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// rtl/instr_fetch_pc_gen.sv - fetch pc register with sequential advance and redirect load
// FETCH_ALIGN_CHK_EN: forces redirect targets to word alignment and flags misaligned ones
module pc_gen
  import fetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  input  logic         advance,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_inc
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic         misalign
`endif
);

  logic [n-1:0] target;

  assign pc_inc = pc + n'(INSTR_BYTES);

`ifdef FETCH_ALIGN_CHK_EN
  assign target = {redirect_pc[n-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign <= 1'b0;
    else        misalign <= redirect && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign target = redirect_pc;
`endif

  // Redirect takes priority over sequential advance in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc <= RESET_PC;
    else if (redirect) pc <= target;
    else if (advance)  pc <= pc_inc;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding fetch stage feeding the IF/ID register
// FETCH_ALIGN_CHK_EN: adds fetch_misalign and aligns redirect targets
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [n-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [n-1:0] instruction_next,
  output logic [n-1:0] pc_next,
  output logic [n-1:0] pc_plus_four_next,
  output logic         fetch_valid
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic         fetch_misalign
`endif
);

  fetch_state_t state, state_d;
  logic         drop, drop_d;
  logic         capture, valid_d;
  logic [n-1:0] pc, pc_inc;

  pc_gen #(.n(n), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (capture),
    .pc          (pc),
    .pc_inc      (pc_inc)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .misalign    (fetch_misalign)
`endif
  );

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_d = state;
    drop_d  = drop;
    capture = 1'b0;
    valid_d = fetch_valid;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          drop_d  = redirect;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          // A redirect seen while waiting poisons the response in flight.
          if (drop || redirect) begin
            state_d = REQ;
          end else begin
            capture = 1'b1;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      drop              <= 1'b0;
      fetch_valid       <= 1'b0;
      instruction_next  <= NOP_INSTR;
      pc_next           <= '0;
      pc_plus_four_next <= '0;
    end else begin
      state       <= state_d;
      drop        <= drop_d;
      fetch_valid <= valid_d;
      if (capture) begin
        instruction_next  <= imem_rdata;
        pc_next           <= pc;
        pc_plus_four_next <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_gnt, imem_rvalid, stall, redirect;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, fetch_valid, imem_req_w, fetch_valid_w;
  logic [31:0] imem_addr, instruction_next, pc_next, pc_plus_four_next;
  logic [31:0] imem_addr_w, instruction_next_w, pc_next_w, pc_plus_four_next_w;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_misalign, fetch_misalign_w;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch #(.n(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction_next(instruction_next), .pc_next(pc_next),
    .pc_plus_four_next(pc_plus_four_next), .fetch_valid(fetch_valid)
`ifdef FETCH_ALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction_next(instruction_next_w), .pc_next(pc_next_w),
    .pc_plus_four_next(pc_plus_four_next_w), .fetch_valid(fetch_valid_w)
`ifdef FETCH_ALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign_w)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Grant in REQ, respond next cycle, then compare the captured word with the scoreboard.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    chk("req_hi", imem_req, 1);
    chk("req_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    sb.push_back({data, addr, addr + 32'd4});
    step();
    imem_rvalid = 1'b0;
    chk("fetch_valid", fetch_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("instr", instruction_next, e.instr);
      chk("pc_next", pc_next, e.pc);
      chk("pc4_next", pc_plus_four_next, e.pc4);
    end
  endtask

  logic [31:0] exp_rd;
  logic [31:0] held_instr;

  initial begin
`ifdef FETCH_ALIGN_CHK_EN
    exp_rd = 32'd248;
`else
    exp_rd = 32'd250;
`endif
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rst_instr", instruction_next, 32'h0000_0013);
    chk("rst_pc", pc_next, 0);
    chk("rst_pc4", pc_plus_four_next, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);
`ifdef FETCH_ALIGN_CHK_EN
    chk("rst_misalign", fetch_misalign, 0);
`endif
    imem_rvalid = 1'b0;
    reset = 1'b1;
    step();

    do_fetch(32'd55, 32'd0);
    chk("next_addr", imem_addr, 4);
    chk("wrap_pc_next", pc_next_w, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_four_next_w, 0);
    chk("wrap_addr", imem_addr_w, 0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", fetch_valid, 1);
      chk("stall_instr", instruction_next, 55);
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    step();
    chk("consumed_valid", fetch_valid, 0);
    chk("consumed_req", imem_req, 1);
    chk("consumed_addr", imem_addr, 4);

    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'd250;
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    chk("misalign_pulse", fetch_misalign, 1);
`endif
    imem_rvalid = 1'b1; imem_rdata = 32'd99;
    step();
    imem_rvalid = 1'b0;
    chk("drop_valid", fetch_valid, 0);
    chk("drop_instr", instruction_next, 55);
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, exp_rd);
`ifdef FETCH_ALIGN_CHK_EN
    chk("misalign_clear", fetch_misalign, 0);
`endif

    do_fetch(32'h0000_1234, exp_rd);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd1444;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("redir_hold_valid", fetch_valid, 0);
    chk("redir_hold_addr", imem_addr, 1444);
    chk("redir_hold_req", imem_req, 1);

    redirect = 1'b1; redirect_pc = 32'd500;
    step();
    redirect_pc = 32'd600;
    step();
    redirect = 1'b0;
    chk("last_redir_addr", imem_addr, 600);
    do_fetch(32'h0000_ABCD, 32'd600);
    step();
    chk("after_fetch_valid", fetch_valid, 0);
    chk("after_fetch_addr", imem_addr, 604);

    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    held_instr = instruction_next;
    chk("pre_reset_instr", held_instr, 32'h0000_ABCD);
    reset = 1'b0;
    #1;
    chk("mid_rst_instr", instruction_next, 32'h0000_0013);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_req", imem_req, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'd77;
    step();
    imem_rvalid = 1'b0;
    chk("stale_valid", fetch_valid, 0);
    chk("stale_req", imem_req, 1);
    chk("stale_addr", imem_addr, 0);
    chk("stale_addr_w", imem_addr_w, 32'hFFFF_FFFC);

    redirect = 1'b1; redirect_pc = 32'd250;
    step();
    redirect = 1'b0;
    chk("align_addr", imem_addr, exp_rd);
`ifdef FETCH_ALIGN_CHK_EN
    chk("align_pulse", fetch_misalign, 1);
    step();
    chk("align_pulse_end", fetch_misalign, 0);
`endif
    chk("align_req", imem_req, 1);

    if (sb.size() != 0) chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
